// File: rtl/front_panel_scan_pkg.sv
// Shared constants and types for the front-panel LED matrix scanner.
// Row indices fix which snapshot byte each matrix row displays.
package front_panel_pkg;

    localparam int NUM_ROWS = 5;

    typedef logic [2:0] row_t;

    localparam row_t ROW_ADDR_LO = 3'd0;
    localparam row_t ROW_ADDR_HI = 3'd1;
    localparam row_t ROW_DATA    = 3'd2;
    localparam row_t ROW_STATUS  = 3'd3;
    localparam row_t ROW_CONTROL = 3'd4;

    localparam logic [7:0] COL_BLANK = 8'hFF;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    function automatic logic [NUM_ROWS-1:0] row_onehot(input row_t r);
        return {{(NUM_ROWS-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/front_panel_scan_if.sv
// Monitor bytes in, matrix drive out. There is no handshake: the scanner free-runs
// and samples the monitor bytes once per frame. brightness exists only with FRONT_PANEL_PWM_EN.
interface front_panel_scan_if;

    logic [15:0] mon_addr;
    logic [7:0]  mon_data;
    logic [7:0]  mon_status;
    logic [7:0]  mon_control;
`ifdef FRONT_PANEL_PWM_EN
    logic [3:0]  brightness;
`endif
    logic [4:0]  led_row;
    logic [7:0]  led_col;
    logic        frame_strobe;

    modport master (
`ifdef FRONT_PANEL_PWM_EN
        output brightness,
`endif
        output mon_addr, mon_data, mon_status, mon_control,
        input  led_row, led_col, frame_strobe
    );

    modport slave (
`ifdef FRONT_PANEL_PWM_EN
        input  brightness,
`endif
        input  mon_addr, mon_data, mon_status, mon_control,
        output led_row, led_col, frame_strobe
    );

endinterface

// File: rtl/front_panel_scan_pwm.sv
// 4-bit brightness duty comparator; compiled only when FRONT_PANEL_PWM_EN is defined.
// A row is lit while the slot's coarse position does not exceed the brightness code.
`ifdef FRONT_PANEL_PWM_EN
module front_panel_pwm (
    input  logic [3:0] pwm_i,
    input  logic [3:0] brightness_i,
    output logic       lit_o
);

    assign lit_o = (pwm_i <= brightness_i);

endmodule
`endif

// File: rtl/front_panel_scan.sv
// Row-multiplexed driver for the 5x8 front-panel LED matrix with per-row blanking.
// Optional feature macro: FRONT_PANEL_PWM_EN adds the brightness duty control.
module front_panel_scan
    import front_panel_pkg::*;
#(
    parameter int ROW_PERIOD   = 512,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               resetn,
    front_panel_scan_if.slave  pif
);

    localparam int CW = $clog2(ROW_PERIOD);

    logic [CW-1:0]         slot_q, slot_d;
    row_t                  row_q, row_d;
    logic [39:0]           snap_q, snap_d;
    logic [NUM_ROWS-1:0]   led_row_q, led_row_d;
    logic [7:0]            led_col_q, led_col_d;
    logic                  strobe_q, strobe_d;
    logic                  frame_start;
    logic                  lit;
    logic [7:0]            row_byte;
    phase_e                phase;

`ifdef FRONT_PANEL_PWM_EN
    front_panel_pwm u_pwm (
        .pwm_i        (slot_q[CW-1 -: 4]),
        .brightness_i (pif.brightness),
        .lit_o        (lit)
    );
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        frame_start = (row_q == ROW_ADDR_LO) && (slot_q == '0);
        // ROW_PERIOD is a power of two, so the slot counter wraps on its own.
        slot_d      = slot_q + 1'b1;
        row_d       = row_q;
        if (slot_q == CW'(ROW_PERIOD - 1)) begin
            row_d = (row_q == ROW_CONTROL) ? ROW_ADDR_LO : row_q + 3'd1;
        end
        snap_d = frame_start
               ? {pif.mon_control, pif.mon_status, pif.mon_data, pif.mon_addr}
               : snap_q;

        case (row_q)
            ROW_ADDR_LO: row_byte = snap_q[7:0];
            ROW_ADDR_HI: row_byte = snap_q[15:8];
            ROW_DATA:    row_byte = snap_q[23:16];
            ROW_STATUS:  row_byte = snap_q[31:24];
            ROW_CONTROL: row_byte = snap_q[39:32];
            default:     row_byte = 8'h00;
        endcase

        phase     = (slot_q < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
        led_row_d = '0;
        led_col_d = COL_BLANK;
        strobe_d  = frame_start;
        if (phase == PH_DRIVE && lit) begin
            led_row_d = row_onehot(row_q);
            led_col_d = ~row_byte;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q    <= '0;
            row_q     <= ROW_ADDR_LO;
            snap_q    <= '0;
            led_row_q <= '0;
            led_col_q <= COL_BLANK;
            strobe_q  <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            row_q     <= row_d;
            snap_q    <= snap_d;
            led_row_q <= led_row_d;
            led_col_q <= led_col_d;
            strobe_q  <= strobe_d;
        end
    end

    assign pif.led_row      = led_row_q;
    assign pif.led_col      = led_col_q;
    assign pif.frame_strobe = strobe_q;

endmodule

// File: tb/tb_front_panel_scan.sv
// Self-checking bench for front_panel_scan (ROW_PERIOD=32, BLANK_CYCLES=4).
// Expected outputs come from a frame/slot arithmetic model of the display schedule.
module tb_front_panel_scan;

  localparam int RP    = 32;
  localparam int BC    = 4;
  localparam int NR    = 5;
  localparam int FRAME = RP * NR;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  front_panel_scan_if ifc();

  front_panel_scan #(.ROW_PERIOD(RP), .BLANK_CYCLES(BC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pif    (ifc)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model: edges since reset release, the frame's captured bytes, brightness at each edge.
  int         n_edges = 0;
  logic       in_reset = 1'b0;
  logic [7:0] model_bytes[NR];
  logic [3:0] model_bright = 4'd15;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] input_byte(int r);
    case (r)
      0: return ifc.mon_addr[7:0];
      1: return ifc.mon_addr[15:8];
      2: return ifc.mon_data;
      3: return ifc.mon_status;
      default: return ifc.mon_control;
    endcase
  endfunction

  function automatic bit pwm_lit(int s);
`ifdef FRONT_PANEL_PWM_EN
    return (s / (RP / 16)) <= int'(model_bright);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [4:0] exp_row();
    int p, s, r;
    if (n_edges == 0) return 5'd0;
    p = (n_edges - 1) % FRAME;
    s = p % RP;
    r = p / RP;
    if (s < BC || !pwm_lit(s)) return 5'd0;
    return 5'(1 << r);
  endfunction

  function automatic logic [7:0] exp_col();
    int r;
    if (exp_row() == 5'd0) return 8'hFF;
    r = ((n_edges - 1) % FRAME) / RP;
    return ~model_bytes[r];
  endfunction

  function automatic logic exp_strobe();
    return (n_edges > 0) && (((n_edges - 1) % FRAME) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!in_reset) begin
      if (n_edges % FRAME == 0)
        for (int r = 0; r < NR; r++) model_bytes[r] = input_byte(r);
`ifdef FRONT_PANEL_PWM_EN
      model_bright = ifc.brightness;
`endif
      n_edges++;
    end
    #1;
  endtask

  // Every-cycle structural properties of led_row.
  logic [4:0] prev_row = 5'd0;
  always @(negedge clk) begin
    vec_cnt++;
    if ($countones(ifc.led_row) > 1) begin
      err_cnt++;
      $display("FAIL onehot: led_row=%b has more than one bit set", ifc.led_row);
    end
    vec_cnt++;
    if (prev_row != 5'd0 && ifc.led_row != 5'd0 && ifc.led_row !== prev_row) begin
      err_cnt++;
      $display("FAIL row_via_blank: led_row went %b -> %b without blank", prev_row, ifc.led_row);
    end
    prev_row = ifc.led_row;
  end

  task automatic test_reset();
    ifc.mon_addr    = 16'hA55A;
    ifc.mon_data    = 8'h3C;
    ifc.mon_status  = 8'h01;
    ifc.mon_control = 8'h10;
    #2;
    resetn   = 1'b0;
    in_reset = 1'b1;
    n_edges  = 0;
    repeat (3) tick();
    vec_cnt++;
    if (ifc.led_row !== 5'd0) begin
      err_cnt++; $display("FAIL reset_row: got %b expected 00000", ifc.led_row);
    end
    vec_cnt++;
    if (ifc.led_col !== 8'hFF) begin
      err_cnt++; $display("FAIL reset_col: got %h expected ff", ifc.led_col);
    end
    vec_cnt++;
    if (ifc.frame_strobe !== 1'b0) begin
      err_cnt++; $display("FAIL reset_strobe: got %b expected 0", ifc.frame_strobe);
    end
    resetn   = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic test_first_frame();
    int strobes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifc.frame_strobe === 1'b1) strobes++;
      vec_cnt++;
      if (ifc.led_row !== exp_row() || ifc.led_col !== exp_col() || ifc.frame_strobe !== exp_strobe()) begin
        err_cnt++;
        $display("FAIL first_frame n=%0d: got row=%b col=%h strb=%b expected row=%b col=%h strb=%b",
                 n_edges, ifc.led_row, ifc.led_col, ifc.frame_strobe, exp_row(), exp_col(), exp_strobe());
      end
      if (n_edges == 4 || n_edges == 33) begin
        vec_cnt++;
        if (ifc.led_row !== 5'd0 || ifc.led_col !== 8'hFF) begin
          err_cnt++; $display("FAIL blank_edge n=%0d: got row=%b col=%h expected 00000/ff", n_edges, ifc.led_row, ifc.led_col);
        end
      end
      if (n_edges == 5 || n_edges == 32) begin
        vec_cnt++;
        if (ifc.led_row !== 5'b00001 || ifc.led_col !== 8'hA5) begin
          err_cnt++; $display("FAIL row0_drive n=%0d: got row=%b col=%h expected 00001/a5", n_edges, ifc.led_row, ifc.led_col);
        end
      end
      if (n_edges == 37) begin
        vec_cnt++;
        if (ifc.led_row !== 5'b00010 || ifc.led_col !== 8'h5A) begin
          err_cnt++; $display("FAIL row1_drive: got row=%b col=%h expected 00010/5a", ifc.led_row, ifc.led_col);
        end
      end
    end
    vec_cnt++;
    if (strobes != 1) begin
      err_cnt++; $display("FAIL first_strobe_count: got %0d expected 1", strobes);
    end
  endtask

  task automatic test_snapshot_hold();
    ifc.mon_data = 8'hFF;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h00);
    while (n_edges < 230) begin
      tick();
      vec_cnt++;
      if (ifc.led_row !== exp_row() || ifc.led_col !== exp_col() || ifc.frame_strobe !== exp_strobe()) begin
        err_cnt++;
        $display("FAIL snapshot n=%0d: got row=%b col=%h strb=%b expected row=%b col=%h strb=%b",
                 n_edges, ifc.led_row, ifc.led_col, ifc.frame_strobe, exp_row(), exp_col(), exp_strobe());
      end
      if ((n_edges == 69 || n_edges == 229) && exp_q.size() > 0) begin
        logic [7:0] want;
        want = exp_q.pop_front();
        vec_cnt++;
        if (ifc.led_row !== 5'b00100 || ifc.led_col !== want) begin
          err_cnt++; $display("FAIL row2_data n=%0d: got row=%b col=%h expected 00100/%h", n_edges, ifc.led_row, ifc.led_col, want);
        end
      end
    end
  endtask

  task automatic test_frames();
    int last_strobe = -1;
    logic [4:0] last_nz = 5'd0;
    int hold = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (hold == 0) begin
        ifc.mon_addr    = 16'($urandom);
        ifc.mon_data    = 8'($urandom);
        ifc.mon_status  = 8'($urandom);
        ifc.mon_control = 8'($urandom);
        hold = $urandom_range(1, 50);
      end else begin
        hold--;
      end
      tick();
      vec_cnt++;
      if (ifc.led_row !== exp_row() || ifc.led_col !== exp_col() || ifc.frame_strobe !== exp_strobe()) begin
        err_cnt++;
        $display("FAIL frames n=%0d: got row=%b col=%h strb=%b expected row=%b col=%h strb=%b",
                 n_edges, ifc.led_row, ifc.led_col, ifc.frame_strobe, exp_row(), exp_col(), exp_strobe());
      end
      if (ifc.frame_strobe === 1'b1) begin
        if (last_strobe >= 0) begin
          vec_cnt++;
          if (n_edges - last_strobe != FRAME) begin
            err_cnt++; $display("FAIL strobe_spacing: got %0d expected %0d", n_edges - last_strobe, FRAME);
          end
        end
        last_strobe = n_edges;
      end
      if (ifc.led_row != 5'd0 && ifc.led_row !== last_nz) begin
        if (last_nz != 5'd0) begin
          logic [4:0] want;
          want = (last_nz == 5'b10000) ? 5'b00001 : (last_nz << 1);
          vec_cnt++;
          if (ifc.led_row !== want) begin
            err_cnt++; $display("FAIL row_sequence: got %b expected %b", ifc.led_row, want);
          end
        end
        last_nz = ifc.led_row;
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 2 * FRAME;
    while (budget > 0 && !((((n_edges - 1) % FRAME) / RP == 3) && (((n_edges - 1) % RP) == 10))) begin
      tick();
      budget--;
    end
    vec_cnt++;
    if (budget == 0) begin
      err_cnt++; $display("FAIL reach_row3: got no row 3 drive cycle expected one within %0d clocks", 2 * FRAME);
    end
    #2;
    resetn   = 1'b0;
    in_reset = 1'b1;
    n_edges  = 0;
    #1;
    vec_cnt++;
    if (ifc.led_row !== 5'd0 || ifc.led_col !== 8'hFF) begin
      err_cnt++; $display("FAIL async_reset: got row=%b col=%h expected 00000/ff", ifc.led_row, ifc.led_col);
    end
    repeat (2) tick();
    ifc.mon_addr    = 16'($urandom);
    ifc.mon_data    = 8'($urandom);
    ifc.mon_status  = 8'($urandom);
    ifc.mon_control = 8'($urandom);
    resetn   = 1'b1;
    in_reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 5) ifc.mon_addr = ~ifc.mon_addr;
      vec_cnt++;
      if (ifc.led_row !== exp_row() || ifc.led_col !== exp_col() || ifc.frame_strobe !== exp_strobe()) begin
        err_cnt++;
        $display("FAIL restart n=%0d: got row=%b col=%h strb=%b expected row=%b col=%h strb=%b",
                 n_edges, ifc.led_row, ifc.led_col, ifc.frame_strobe, exp_row(), exp_col(), exp_strobe());
      end
      if (n_edges == 1) begin
        vec_cnt++;
        if (ifc.frame_strobe !== 1'b1) begin
          err_cnt++; $display("FAIL restart_strobe: got %b expected 1", ifc.frame_strobe);
        end
      end
    end
  endtask

`ifdef FRONT_PANEL_PWM_EN
  task automatic test_pwm();
    logic [3:0] levels[4];
    levels[0] = 4'd0;
    levels[1] = 4'd7;
    levels[2] = 4'd15;
    levels[3] = 4'($urandom_range(1, 14));
    for (int k = 0; k < 4; k++) begin
      int lit_cnt = 0;
      int want = 0;
      for (int s = BC; s < RP; s++) if ((s / (RP / 16)) <= int'(levels[k])) want++;
      ifc.brightness = levels[k];
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (ifc.led_row != 5'd0) lit_cnt++;
        vec_cnt++;
        if (ifc.led_row !== exp_row() || ifc.led_col !== exp_col()) begin
          err_cnt++;
          $display("FAIL pwm_cycle b=%0d n=%0d: got row=%b col=%h expected row=%b col=%h",
                   levels[k], n_edges, ifc.led_row, ifc.led_col, exp_row(), exp_col());
        end
      end
      vec_cnt++;
      if (lit_cnt != NR * want) begin
        err_cnt++; $display("FAIL pwm_lit_count b=%0d: got %0d expected %0d", levels[k], lit_cnt, NR * want);
      end
    end
    ifc.brightness = 4'd15;
  endtask
`endif

  initial begin
    ifc.mon_addr    = 16'h0000;
    ifc.mon_data    = 8'h00;
    ifc.mon_status  = 8'h00;
    ifc.mon_control = 8'h00;
`ifdef FRONT_PANEL_PWM_EN
    ifc.brightness  = 4'd15;
`endif
    test_reset();
    test_first_frame();
    test_snapshot_hold();
    test_frames();
    test_reset_mid();
`ifdef FRONT_PANEL_PWM_EN
    test_pwm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
